// File: rtl/cl_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// cl_capture_ctrl_if
// Message bus between the host command channel, the capture controller and
// the downstream status FIFO.
//   pc_msg_pending  host -> ctrl : a command word is present on pc_msg
//   pc_msg[31:0]    host -> ctrl : [31:20] opcode, [19:16] reserved, [15:0] arg
//   pc_msg_ack      ctrl -> host : one-cycle pulse, command consumed
//   fpga_msg_full   fifo -> ctrl : downstream status FIFO cannot accept
//   fpga_msg[31:0]  ctrl -> fifo : status word
//   fpga_msg_valid  ctrl -> fifo : one-cycle write strobe for fpga_msg
// modport master : environment side (host + FIFO)
// modport slave  : capture controller side
// ---------------------------------------------------------------------------
interface cl_capture_ctrl_if;
    logic        pc_msg_pending;
    logic [31:0] pc_msg;
    logic        pc_msg_ack;
    logic        fpga_msg_full;
    logic [31:0] fpga_msg;
    logic        fpga_msg_valid;

    modport master (
        output pc_msg_pending,
        output pc_msg,
        output fpga_msg_full,
        input  pc_msg_ack,
        input  fpga_msg,
        input  fpga_msg_valid
    );

    modport slave (
        input  pc_msg_pending,
        input  pc_msg,
        input  fpga_msg_full,
        output pc_msg_ack,
        output fpga_msg,
        output fpga_msg_valid
    );
endinterface

// File: rtl/cl_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cl_capture_ctrl
// Camera Link capture sequencer. A host ARM command requests N frames; each
// frame that starts after arming is captured (pix_en follows fval & lval one
// cycle late), its lines are counted and a status word is produced at the end
// of the frame. ABORT returns to IDLE at once. Status words pass through a
// one-deep slot towards the downstream FIFO.
// Ports:
//   cl_clk       : sole clock, rising edge
//   reset        : synchronous, active low
//   msg          : cl_capture_ctrl_if.slave (host command + status FIFO bus)
//   cl_fval      : Camera Link frame valid
//   cl_lval      : Camera Link line valid
//   pix_en       : registered pixel-capture enable
//   busy         : state is not IDLE
//   status_drop  : sticky, a frame status word was lost
// Parameter:
//   MAX_LINE_CNT : saturation value of the per-frame line counter
// ---------------------------------------------------------------------------
module cl_capture_ctrl #(
    parameter logic [15:0] MAX_LINE_CNT = 16'hFFFF
) (
    input  logic                     cl_clk,
    input  logic                     reset,
    cl_capture_ctrl_if.slave         msg,
    input  logic                     cl_fval,
    input  logic                     cl_lval,
    output logic                     pix_en,
    output logic                     busy,
    output logic                     status_drop
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [11:0] OP_ARM   = 12'h001;
    localparam logic [11:0] OP_ABORT = 12'h002;

    // Status word layout: type, overflow, 11-bit frame index, line count.
    function automatic logic [31:0] make_status(input logic [3:0]  typ,
                                                input logic        ovf,
                                                input logic [10:0] idx,
                                                input logic [15:0] lines);
        make_status = {typ, ovf, idx, lines};
    endfunction

    state_t      state_q,     state_d;
    logic        fval_q,      lval_q;
    logic [15:0] n_q,         n_d;
    logic [15:0] frame_idx_q, frame_idx_d;
    logic [15:0] line_cnt_q,  line_cnt_d;
    logic        ovf_q,       ovf_d;
    logic        pix_en_q,    pix_en_d;
    logic        ack_q,       ack_d;
    logic        slot_full_q, slot_full_d;
    logic [31:0] slot_word_q, slot_word_d;
    logic        busy_q,      busy_d;
    logic        drop_q,      drop_d;

    logic        fval_rise_s, fval_fall_s, lval_rise_s;
    logic        issue_s, slot_free_s, accept_s, abort_s;
    logic        in_cap_s, frame_end_s, final_s, ovf_now_s;
    logic [11:0] opcode_s;
    logic [15:0] arg_s;
    logic [15:0] idx_inc_s;
    logic        cmd_st_s, frm_st_s;
    logic [31:0] cmd_word_s, frm_word_s;
    logic        unused_rsvd_s;

    // Edge detection, command decode and slot handshake terms.
    always_comb begin
        fval_rise_s   = cl_fval & ~fval_q;
        fval_fall_s   = ~cl_fval & fval_q;
        lval_rise_s   = cl_lval & ~lval_q;
        opcode_s      = msg.pc_msg[31:20];
        arg_s         = msg.pc_msg[15:0];
        unused_rsvd_s = ^msg.pc_msg[19:16];
        issue_s       = slot_full_q & ~msg.fpga_msg_full;
        // A slot being issued this cycle can take a new frame word.
        slot_free_s   = ~slot_full_q | issue_s;
        // ack_q blocks acceptance of the same word on the cycle after an ack.
        accept_s      = msg.pc_msg_pending & ~slot_full_q & ~ack_q;
        abort_s       = accept_s & (opcode_s == OP_ABORT);
        // The cycle in which ARMED sees the frame start already captures.
        in_cap_s      = (state_q == ST_CAPTURE) | ((state_q == ST_ARMED) & fval_rise_s);
        frame_end_s   = (state_q == ST_CAPTURE) & fval_fall_s;
        idx_inc_s     = frame_idx_q + 16'd1;
        final_s       = (idx_inc_s == n_q);
        // The last pix_en cycle of a frame may coincide with the fval fall.
        ovf_now_s     = ovf_q | (pix_en_q & msg.fpga_msg_full);
    end

    // Next-state logic for the sequencer, counters and status slot.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        frame_idx_d = frame_idx_q;
        line_cnt_d  = line_cnt_q;
        ovf_d       = ovf_q;
        slot_full_d = issue_s ? 1'b0 : slot_full_q;
        slot_word_d = slot_word_q;
        drop_d      = drop_q;
        cmd_st_s    = 1'b0;
        cmd_word_s  = 32'd0;
        frm_st_s    = 1'b0;
        frm_word_s  = 32'd0;

        if (accept_s) begin
            case (opcode_s)
                OP_ARM: begin
                    if (state_q == ST_IDLE) begin
                        if (arg_s != 16'd0) begin
                            n_d         = arg_s;
                            frame_idx_d = 16'd0;
                            line_cnt_d  = 16'd0;
                            ovf_d       = 1'b0;
                            state_d     = ST_ARMED;
                        end else begin
                            cmd_st_s   = 1'b1;
                            cmd_word_s = make_status(4'hE, 1'b0, 11'd0, 16'd0);
                        end
                    end else begin
                        cmd_st_s   = 1'b1;
                        cmd_word_s = make_status(4'hB, 1'b0, 11'd0, 16'd0);
                    end
                end
                OP_ABORT: begin
                    state_d    = ST_IDLE;
                    line_cnt_d = 16'd0;
                    ovf_d      = 1'b0;
                    cmd_st_s   = 1'b1;
                    cmd_word_s = make_status(4'h2, 1'b0, frame_idx_q[10:0], 16'd0);
                end
                default: begin
                    cmd_st_s   = 1'b1;
                    cmd_word_s = make_status(4'hE, 1'b0, 11'd0, 16'd0);
                end
            endcase
        end else begin
            cmd_st_s = 1'b0;
        end

        // ABORT overrides all frame tracking, including a coincident frame end.
        if (!abort_s) begin
            if ((state_q == ST_ARMED) && fval_rise_s) begin
                state_d = ST_CAPTURE;
            end else begin
                state_d = state_d;
            end

            if (in_cap_s && lval_rise_s && (line_cnt_q != MAX_LINE_CNT)) begin
                line_cnt_d = line_cnt_q + 16'd1;
            end else begin
                line_cnt_d = line_cnt_d;
            end

            if ((state_q == ST_CAPTURE) && pix_en_q && msg.fpga_msg_full) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_d;
            end

            if (frame_end_s) begin
                frame_idx_d = idx_inc_s;
                line_cnt_d  = 16'd0;
                ovf_d       = 1'b0;
                state_d     = final_s ? ST_IDLE : ST_ARMED;
                frm_st_s    = 1'b1;
                frm_word_s  = make_status(final_s ? 4'h3 : 4'h1, ovf_now_s,
                                          idx_inc_s[10:0], line_cnt_q);
            end else begin
                frm_st_s = 1'b0;
            end
        end else begin
            frm_st_s = 1'b0;
        end

        // A command status owns the slot; a frame word arriving with it is lost.
        if (cmd_st_s) begin
            slot_full_d = 1'b1;
            slot_word_d = cmd_word_s;
            drop_d      = drop_q | frm_st_s;
        end else if (frm_st_s && slot_free_s) begin
            slot_full_d = 1'b1;
            slot_word_d = frm_word_s;
        end else if (frm_st_s) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Registered output terms derived from the next state.
    always_comb begin
        pix_en_d = in_cap_s & cl_fval & cl_lval & ~abort_s;
        ack_d    = accept_s;
        busy_d   = (state_d != ST_IDLE);
    end

    // Sequencer state and all registered outputs, synchronous active-low reset.
    always_ff @(posedge cl_clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            n_q         <= 16'd0;
            frame_idx_q <= 16'd0;
            line_cnt_q  <= 16'd0;
            ovf_q       <= 1'b0;
            pix_en_q    <= 1'b0;
            ack_q       <= 1'b0;
            slot_full_q <= 1'b0;
            slot_word_q <= 32'd0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fval_q      <= cl_fval;
            lval_q      <= cl_lval;
            n_q         <= n_d;
            frame_idx_q <= frame_idx_d;
            line_cnt_q  <= line_cnt_d;
            ovf_q       <= ovf_d;
            pix_en_q    <= pix_en_d;
            ack_q       <= ack_d;
            slot_full_q <= slot_full_d;
            slot_word_q <= slot_word_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    // The write strobe must react to fpga_msg_full in the cycle it is seen.
    assign msg.fpga_msg_valid = issue_s;
    assign msg.fpga_msg       = slot_word_q;
    assign msg.pc_msg_ack     = ack_q;
    assign pix_en             = pix_en_q;
    assign busy               = busy_q;
    assign status_drop        = drop_q;

endmodule
